// File: rtl/serial_frame_rx_if.sv
// Sample-word handshake between serial_frame_rx (master) and its FIFO consumer (slave).
interface serial_frame_rx_if;
  logic [15:0] out_data;
  logic        out_first;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, out_first, out_valid, input out_ready);
  modport slave  (input out_data, out_first, out_valid, output out_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Bit-synchronous deframer for paired 16-bit samples with a FWFT sample FIFO.
// Optional even-parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int HUNT_LEN   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  serial_frame_rx_if.master           m_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_error,
  output logic                        overflow,
`ifdef SERIAL_RX_PARITY_EN
  output logic                        parity_error,
`endif
  input  logic                        clear_errors
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HUNT_LEN + 1);

  typedef enum logic [2:0] {HUNT, IDLE, DATA, PAR, STOP, PUSH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [HW-1:0] hunt_q, hunt_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sr_q, sr_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d, free;
  logic          ferr_q, ferr_d, ovf_q, ovf_d;
  logic          s, push, pop, ferr_set, ovf_set;
  logic [16:0]   push_word, head;
  logic [16:0]   mem_q [FIFO_DEPTH];
`ifdef SERIAL_RX_PARITY_EN
  logic          perr_q, perr_d, perr_set;
`endif

  assign s    = sync_q[1];
  assign free = LW'(FIFO_DEPTH) - lvl_q;
  assign pop  = m_if.out_valid && m_if.out_ready;

  always_comb begin
    state_d   = state_q;
    hunt_d    = '0;
    bit_d     = bit_q;
    sr_d      = sr_q;
    push      = 1'b0;
    push_word = '0;
    ferr_set  = 1'b0;
    ovf_set   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        if (s) begin
          if (hunt_q == HW'(HUNT_LEN - 1)) state_d = IDLE;
          else                             hunt_d  = hunt_q + HW'(1);
        end
      end
      IDLE: begin
        if (!s) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        sr_d  = {sr_q[30:0], s};
        bit_d = bit_q + 5'd1;
`ifdef SERIAL_RX_PARITY_EN
        if (bit_q == 5'd31) state_d = PAR;
`else
        if (bit_q == 5'd31) state_d = STOP;
`endif
      end
`ifdef SERIAL_RX_PARITY_EN
      PAR: begin
        if ((^sr_q) ^ s) begin
          perr_set = 1'b1;
          state_d  = HUNT;
        end else begin
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (!s) begin
          ferr_set = 1'b1;
          state_d  = HUNT;
        end else if (free < LW'(2)) begin
          // Space for both words is reserved here so a frame is never split.
          ovf_set  = 1'b1;
          state_d  = IDLE;
        end else begin
          push      = 1'b1;
          push_word = {1'b1, sr_q[31:16]};
          state_d   = PUSH;
        end
      end
      PUSH: begin
        push      = 1'b1;
        push_word = {1'b0, sr_q[15:0]};
        if (!s) begin
          state_d = DATA;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    sync_d = {sync_q[0], serial_in};
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop  ? rd_q + AW'(1) : rd_q;
    lvl_d  = lvl_q + LW'(push) - LW'(pop);
    // A new error in the same cycle as clear_errors wins.
    ferr_d = ferr_set | (ferr_q & ~clear_errors);
    ovf_d  = ovf_set  | (ovf_q  & ~clear_errors);
`ifdef SERIAL_RX_PARITY_EN
    perr_d = perr_set | (perr_q & ~clear_errors);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      sync_q  <= 2'b11;
      hunt_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hunt_q  <= hunt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Storage needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_word;
  end

  assign head             = mem_q[rd_q];
  assign m_if.out_valid   = (lvl_q != '0);
  assign m_if.out_data    = m_if.out_valid ? head[15:0] : 16'h0000;
  assign m_if.out_first   = m_if.out_valid ? head[16]   : 1'b0;
  assign fifo_level       = lvl_q;
  assign frame_error      = ferr_q;
  assign overflow         = ovf_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error     = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed, table-driven bench for serial_frame_rx (FIFO_DEPTH=8, HUNT_LEN=4).
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       clear_errors = 1'b0;
  logic [3:0] fifo_level;
  logic       frame_error, overflow;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_error;
`endif

  serial_frame_rx_if bus();

  serial_frame_rx #(.FIFO_DEPTH(8), .HUNT_LEN(4)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .serial_in   (serial_in),
    .m_if        (bus),
    .fifo_level  (fifo_level),
    .frame_error (frame_error),
    .overflow    (overflow),
`ifdef SERIAL_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .clear_errors(clear_errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        stop;
    logic        clr;
    int          gap;
    logic        store;
    logic        ferr;
  } vec_t;

  vec_t        vecs [5];
  int          tests = 0;
  int          fails = 0;
  logic [16:0] got_q [$];
  logic [16:0] exp_q [$];

  // A transfer happens at the next posedge whenever valid&&ready hold at negedge.
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_first, bus.out_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bitx(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) bitx(1'b1);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic stop);
    logic [31:0] w;
    w = {a, b};
    bitx(1'b0);
    for (int i = 31; i >= 0; i--) bitx(w[i]);
`ifdef SERIAL_RX_PARITY_EN
    bitx(^w);
`endif
    bitx(stop);
  endtask

  task automatic expect_frame(input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back({1'b1, a});
    exp_q.push_back({1'b0, b});
  endtask

  task automatic compare_words(input string name);
    chk($sformatf("%s_count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    bitx(1'b1);
    clear_errors = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    vecs[0] = '{16'h1234, 16'hABCD, 1'b1, 1'b0, 6, 1'b1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 6, 1'b1, 1'b0};
    vecs[2] = '{16'h8001, 16'h7FFE, 1'b0, 1'b0, 6, 1'b0, 1'b1};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 6, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 6, 1'b1, 1'b0};

    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_valid", bus.out_valid, 0);
    chk("rst_first", bus.out_first, 0);
    chk("rst_data",  bus.out_data,  0);
    chk("rst_level", fifo_level,    0);
    chk("rst_ferr",  frame_error,   0);
    chk("rst_ovf",   overflow,      0);

    // Latency: stop bit in cycle S, word A visible in S+3, word B in S+4.
    idle(8);
    send_frame(16'h1234, 16'hABCD, 1'b1);
    chk("lat_s1_valid", bus.out_valid, 0);
    idle(2);
    chk("lat_s3_valid", bus.out_valid, 1);
    chk("lat_s3_data",  bus.out_data,  32'h1234);
    chk("lat_s3_first", bus.out_first, 1);
    idle(1);
    chk("lat_s4_valid", bus.out_valid, 1);
    chk("lat_s4_data",  bus.out_data,  32'hABCD);
    chk("lat_s4_first", bus.out_first, 0);
    idle(1);
    chk("lat_s5_valid", bus.out_valid, 0);
    chk("lat_ferr", frame_error, 0);
    chk("lat_ovf",  overflow,    0);
    got_q.delete();
    idle(4);

    foreach (vecs[i]) begin
      if (vecs[i].clr) pulse_clear();
      send_frame(vecs[i].a, vecs[i].b, vecs[i].stop);
      idle(vecs[i].gap);
      chk($sformatf("vec%0d_ferr", i), frame_error, vecs[i].ferr);
      chk($sformatf("vec%0d_ovf", i),  overflow,    0);
      if (vecs[i].store) expect_frame(vecs[i].a, vecs[i].b);
    end
    idle(4);
    compare_words("table");

    // Three frames with no idle bits between them.
    send_frame(16'hA5A5, 16'h5A5A, 1'b1);
    send_frame(16'h0001, 16'h8000, 1'b1);
    send_frame(16'hDEAD, 16'hBEEF, 1'b1);
    idle(8);
    expect_frame(16'hA5A5, 16'h5A5A);
    expect_frame(16'h0001, 16'h8000);
    expect_frame(16'hDEAD, 16'hBEEF);
    compare_words("b2b");
    chk("b2b_ferr", frame_error, 0);

    // Bad stop, then a frame after only 2 idle bits is ignored (still hunting).
    send_frame(16'h5555, 16'h5555, 1'b0);
    idle(2);
    send_frame(16'h5555, 16'h5555, 1'b1);
    idle(10);
    compare_words("hunt_ignored");
    chk("hunt_ferr", frame_error, 1);
    send_frame(16'hC0DE, 16'h0123, 1'b1);
    idle(6);
    expect_frame(16'hC0DE, 16'h0123);
    compare_words("hunt_after");
    pulse_clear();
    idle(1);
    chk("clear_ferr", frame_error, 0);

    // Overflow: consumer stalled, fifth frame must be dropped whole.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b1);
    idle(4);
    chk("ovf_level_full", fifo_level, 8);
    chk("ovf_before", overflow, 0);
    send_frame(16'h1004, 16'h2004, 1'b1);
    idle(4);
    chk("ovf_set",   overflow,      1);
    chk("ovf_level", fifo_level,    8);
    chk("ovf_hold_data",  bus.out_data,  32'h1000);
    chk("ovf_hold_first", bus.out_first, 1);
    for (int k = 0; k < 4; k++) expect_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k));
    bus.out_ready = 1'b1;
    idle(12);
    compare_words("ovf_drain");
    chk("ovf_level_empty", fifo_level, 0);
    pulse_clear();
    idle(1);
    chk("clear_ovf", overflow, 0);

    // Reset mid-frame loses buffered words and the partial frame.
    bus.out_ready = 1'b0;
    send_frame(16'h7777, 16'h8888, 1'b1);
    idle(4);
    chk("pre_rst_level", fifo_level, 2);
    w = 32'h5555_5555;
    bitx(1'b0);
    for (int i = 31; i >= 22; i--) bitx(w[i]);
    rst_n = 1'b0;
    for (int i = 21; i >= 19; i--) bitx(w[i]);
    chk("midrst_level", fifo_level,    0);
    chk("midrst_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    for (int i = 18; i >= 0; i--) bitx(w[i]);
`ifdef SERIAL_RX_PARITY_EN
    bitx(^w);
`endif
    bitx(1'b1);
    idle(10);
    chk("midrst_after_level", fifo_level, 0);
    got_q.delete();
    bus.out_ready = 1'b1;
    send_frame(16'hCAFE, 16'hF00D, 1'b1);
    idle(6);
    expect_frame(16'hCAFE, 16'hF00D);
    compare_words("midrst_clean");
    chk("midrst_ferr", frame_error, 0);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(16'h1357, 16'h2468, 1'b1);
    idle(6);
    expect_frame(16'h1357, 16'h2468);
    compare_words("par_good");
    chk("par_good_perr", parity_error, 0);
    w = 32'h0F0E_1234;
    bitx(1'b0);
    for (int i = 31; i >= 0; i--) bitx(w[i]);
    bitx(~(^w));
    bitx(1'b1);
    idle(8);
    compare_words("par_bad");
    chk("par_bad_perr", parity_error, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
